// File: rtl/audio_mixer_mc.sv
// audio_mixer_mc: time-multiplexed stereo mixer for NCH unsigned channels.
// A strobe snapshots all inputs. A single adder pair then walks the channels,
// one per cycle. A final cycle scales the sums, adds the tape term and limits
// the result to OUT_W bits.
// Optional feature macro: MIXER_SAT_EN. When defined, the final sums clamp to
// full scale. When undefined, the final sums wrap modulo 2^OUT_W.
module audio_mixer_mc #(
  parameter int NCH   = 3,
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
) (
  input  logic                  clk_sys,
  input  logic                  RESET,
  input  logic                  ce_sample,
  input  logic [NCH*IN_W-1:0]   ch_in,
  input  logic [2*NCH-1:0]      pan,
  input  logic [2*NCH-1:0]      att,
  input  logic                  mono,
  input  logic                  tape_bit,
  input  logic [1:0]            tape_vol,
  output logic [OUT_W-1:0]      audio_l,
  output logic [OUT_W-1:0]      audio_r,
  output logic                  valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int ACC_W = IN_W + $clog2(NCH) + 1;
  localparam int SUM_W = OUT_W + $clog2(NCH) + 1;
  localparam int SH    = OUT_W - IN_W - 2;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL} state_t;

  state_t            state, state_nxt;
  logic [IN_W-1:0]   snap_ch  [NCH];
  logic [1:0]        snap_pan [NCH];
  logic [1:0]        snap_att [NCH];
  logic              snap_mono, snap_tape_bit;
  logic [1:0]        snap_tape_vol;
  logic [ACC_W-1:0]  acc_l, acc_r;
  logic [IDX_W-1:0]  idx;
  logic              start, last_ch, in_accum, in_final;
  logic [IN_W-1:0]   cur_v;
  logic              add_l, add_r;
  logic [OUT_W-1:0]  tape_term;

  // Scale the accumulated sum to output range, add the tape term and limit.
  function automatic logic [OUT_W-1:0] limit(input logic [ACC_W-1:0] acc,
                                             input logic [OUT_W-1:0] t);
`ifdef MIXER_SAT_EN
    logic [SUM_W-1:0] s;
    s = ({{(SUM_W-ACC_W){1'b0}}, acc} << SH) + {{(SUM_W-OUT_W){1'b0}}, t};
    limit = (|s[SUM_W-1:OUT_W]) ? '1 : s[OUT_W-1:0];
`else
    limit = OUT_W'(({{(SUM_W-ACC_W){1'b0}}, acc} << SH) + {{(SUM_W-OUT_W){1'b0}}, t});
`endif
  endfunction

  // State register.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: idle until a strobe, walk channels, one final cycle.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (ce_sample) state_nxt = S_ACCUM;
      S_ACCUM: if (last_ch)   state_nxt = S_FINAL;
      S_FINAL: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM decoded outputs.
  always_comb begin
    start    = (state == S_IDLE) && ce_sample;
    in_accum = (state == S_ACCUM);
    in_final = (state == S_FINAL);
    last_ch  = in_accum && (idx == LAST_IDX);
    busy     = (state != S_IDLE);
  end

  // Snapshot of the mix inputs at the accepted strobe.
  // NOTE: the snapshot holds only data and is always loaded before use, so it has no reset.
  always_ff @(posedge clk_sys) begin
    if (start) begin
      for (int k = 0; k < NCH; k++) begin
        snap_ch[k]  <= ch_in[k*IN_W +: IN_W];
        snap_pan[k] <= pan[2*k +: 2];
        snap_att[k] <= att[2*k +: 2];
      end
      snap_mono     <= mono;
      snap_tape_bit <= tape_bit;
      snap_tape_vol <= tape_vol;
    end
  end

  // Attenuated value and left/right routing of the current channel.
  always_comb begin
    cur_v = '0;
    if (snap_att[idx] != 2'd3) cur_v = snap_ch[idx] >> snap_att[idx];
    add_l = snap_pan[idx][0] || (snap_mono && (snap_pan[idx] != 2'b00));
    add_r = snap_pan[idx][1] || (snap_mono && (snap_pan[idx] != 2'b00));
  end

  // Tape monitor term added to both sides in the final cycle.
  always_comb begin
    tape_term = '0;
    if (snap_tape_bit) begin
      case (snap_tape_vol)
        2'd1:       tape_term[OUT_W-10] = 1'b1;
        2'd2, 2'd3: tape_term[OUT_W-9]  = 1'b1;
        default:    tape_term = '0;
      endcase
    end
  end

  // Accumulators, channel index, output registers and status pulses.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      acc_l   <= '0;
      acc_r   <= '0;
      idx     <= '0;
      audio_l <= '0;
      audio_r <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= ce_sample && busy;
      if (start) begin
        acc_l <= '0;
        acc_r <= '0;
        idx   <= '0;
      end else if (in_accum) begin
        if (add_l) acc_l <= acc_l + ACC_W'(cur_v);
        if (add_r) acc_r <= acc_r + ACC_W'(cur_v);
        idx <= idx + IDX_W'(1);
      end else if (in_final) begin
        audio_l <= limit(acc_l, tape_term);
        audio_r <= limit(acc_r, tape_term);
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_mixer_mc.sv
// Testbench for audio_mixer_mc. Two instances are used: NCH=3 (dut_a) and
// NCH=5 (dut_b). A timeline model predicts valid/busy/overrun/audio of dut_a
// on every cycle. Directed scenarios add literal expectations.
module tb_audio_mixer_mc;
  localparam int IN_W  = 12;
  localparam int OUT_W = 16;
  localparam int NCH_A = 3;
  localparam int NCH_B = 5;

  logic clk_sys = 1'b0;
  logic RESET = 1'b1;
  logic ce_a = 1'b0, ce_b = 1'b0;
  logic mono = 1'b0, tape_bit = 1'b0;
  logic [1:0] tape_vol = 2'd0;
  logic [NCH_A*IN_W-1:0] ch_a = '0;
  logic [2*NCH_A-1:0] pan_a = '0, att_a = '0;
  logic [NCH_B*IN_W-1:0] ch_b = '0;
  logic [2*NCH_B-1:0] pan_b = '0, att_b = '0;
  logic [OUT_W-1:0] audio_l_a, audio_r_a, audio_l_b, audio_r_b;
  logic valid_a, busy_a, overrun_a, valid_b, busy_b, overrun_b;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  audio_mixer_mc #(.NCH(NCH_A), .IN_W(IN_W), .OUT_W(OUT_W)) dut_a (
    .clk_sys(clk_sys), .RESET(RESET), .ce_sample(ce_a), .ch_in(ch_a),
    .pan(pan_a), .att(att_a), .mono(mono), .tape_bit(tape_bit),
    .tape_vol(tape_vol), .audio_l(audio_l_a), .audio_r(audio_r_a),
    .valid(valid_a), .busy(busy_a), .overrun(overrun_a));

  audio_mixer_mc #(.NCH(NCH_B), .IN_W(IN_W), .OUT_W(OUT_W)) dut_b (
    .clk_sys(clk_sys), .RESET(RESET), .ce_sample(ce_b), .ch_in(ch_b),
    .pan(pan_b), .att(att_b), .mono(mono), .tape_bit(tape_bit),
    .tape_vol(tape_vol), .audio_l(audio_l_b), .audio_r(audio_r_b),
    .valid(valid_b), .busy(busy_b), .overrun(overrun_b));

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Reference mix of one side (0 = left, 1 = right) straight from the mixing rules.
  function automatic int exp_side(input int nch, input logic [191:0] chv,
                                  input logic [31:0] panv, input logic [31:0] attv,
                                  input logic mono_v, input int side,
                                  input logic tbit, input logic [1:0] tvol);
    longint s = 0;
    for (int k = 0; k < nch; k++) begin
      int c = int'(chv[k*IN_W +: IN_W]);
      int p = int'(panv[2*k +: 2]);
      int a = int'(attv[2*k +: 2]);
      if (p != 0 && a != 3 && (mono_v || p[side] == 1'b1)) s += c / (1 << a);
    end
    s = s * (1 << (OUT_W - IN_W - 2));
    if (tbit) s += (tvol == 2'd0) ? 0 : (tvol == 2'd1) ? (1 << (OUT_W-10)) : (1 << (OUT_W-9));
`ifdef MIXER_SAT_EN
    if (s > 65535) s = 65535;
`else
    s = s % 65536;
`endif
    return int'(s);
  endfunction

  // Timeline model of dut_a: an accepted strobe at edge e keeps it busy after
  // edges e..e+NCH and delivers data after edge e+NCH+1.
  bit m_valid = 0, m_busy = 0, m_over = 0;
  int m_l = 0, m_r = 0, pend_l = 0, pend_r = 0, m_acc_edge = -1;
  initial forever begin
    @(posedge clk_sys);
    if (RESET) begin
      m_acc_edge = -1; m_valid = 0; m_busy = 0; m_over = 0; m_l = 0; m_r = 0;
    end else begin
      m_over  = ce_a && m_busy;
      m_valid = (m_acc_edge >= 0) && (edge_n == m_acc_edge + NCH_A + 1);
      if (m_valid) begin m_l = pend_l; m_r = pend_r; end
      if (ce_a && !m_busy) begin
        m_acc_edge = edge_n;
        pend_l = exp_side(NCH_A, 192'(ch_a), 32'(pan_a), 32'(att_a), mono, 0, tape_bit, tape_vol);
        pend_r = exp_side(NCH_A, 192'(ch_a), 32'(pan_a), 32'(att_a), mono, 1, tape_bit, tape_vol);
      end
      m_busy = (m_acc_edge >= 0) && (edge_n >= m_acc_edge) && (edge_n <= m_acc_edge + NCH_A);
    end
    edge_n++;
  end

  // Per-cycle comparison of dut_a against the model.
  initial forever begin
    @(negedge clk_sys);
    if (chk_en) begin
      check($sformatf("valid@%0d", edge_n), int'(valid_a), int'(m_valid));
      check($sformatf("busy@%0d", edge_n), int'(busy_a), int'(m_busy));
      check($sformatf("overrun@%0d", edge_n), int'(overrun_a), int'(m_over));
      check($sformatf("audio_l@%0d", edge_n), int'(audio_l_a), m_l);
      check($sformatf("audio_r@%0d", edge_n), int'(audio_r_a), m_r);
    end
  end

  // Strobe dut_a and wait (bounded) for valid; reports latency and busy cycles.
  task automatic mix_a(input bit zero_after, output int lat, output int nbusy,
                       output int l, output int r);
    ce_a = 1'b1;
    tick();
    ce_a = 1'b0;
    if (zero_after) ch_a = '0;
    lat = 1;
    nbusy = 0;
    while (valid_a !== 1'b1 && lat < 30) begin
      nbusy += int'(busy_a);
      tick();
      lat++;
    end
    l = int'(audio_l_a);
    r = int'(audio_r_a);
  endtask

  task automatic set_basic();
    ch_a = {12'd300, 12'd200, 12'd100};
    pan_a = {2'b11, 2'b10, 2'b01};
    att_a = '0;
    mono = 1'b0; tape_bit = 1'b0; tape_vol = 2'd0;
  endtask

  initial begin
    int lat, nbusy, l, r, nvalid;
`ifdef MIXER_SAT_EN
    int sat_exp = 65535;
`else
    int sat_exp = 16364;
`endif
    // Pin the model with hand-computed values.
    check("model basic L", exp_side(3, 192'({12'd300, 12'd200, 12'd100}), 32'(6'b111001), 32'd0, 1'b0, 0, 1'b0, 2'd0), 1600);
    check("model basic R", exp_side(3, 192'({12'd300, 12'd200, 12'd100}), 32'(6'b111001), 32'd0, 1'b0, 1, 1'b0, 2'd0), 2000);
    check("model att/mono/tape", exp_side(3, 192'({12'd400, 12'd400, 12'd400}), 32'(6'b100001), 32'(6'b110100), 1'b1, 0, 1'b1, 2'd2), 1728);
    check("model sat", exp_side(5, 192'({60{1'b1}}), 32'(10'h3FF), 32'd0, 1'b0, 0, 1'b0, 2'd0), sat_exp);

    // Reset state.
    tick(); tick();
    check("reset audio_l", int'(audio_l_a), 0);
    check("reset audio_r", int'(audio_r_a), 0);
    check("reset valid", int'(valid_a), 0);
    check("reset busy", int'(busy_a), 0);
    check("reset overrun", int'(overrun_a), 0);
    RESET = 1'b0;
    chk_en = 1'b1;
    tick(); tick();

    // Basic pan.
    set_basic();
    mix_a(1'b0, lat, nbusy, l, r);
    check("basic latency", lat, 5);
    check("basic busy cycles", nbusy, 4);
    check("basic L", l, 1600);
    check("basic R", r, 2000);
    tick(); tick();

    // Attenuation, mono and tape.
    ch_a = {12'd400, 12'd400, 12'd400};
    att_a = {2'd3, 2'd1, 2'd0};
    pan_a = {2'b10, 2'b00, 2'b01};
    mono = 1'b1; tape_bit = 1'b1; tape_vol = 2'd2;
    mix_a(1'b0, lat, nbusy, l, r);
    check("attn L", l, 1728);
    check("attn R", r, 1728);

    // Snapshot: inputs cleared one cycle after the strobe.
    set_basic();
    mix_a(1'b1, lat, nbusy, l, r);
    check("snapshot L", l, 1600);
    check("snapshot R", r, 2000);
    tick(); tick();

    // Overrun: strobes at cycles 0 and 2, then at cycle 5.
    set_basic();
    ce_a = 1'b1; tick(); ce_a = 1'b0;          // cycle 1
    tick();                                    // cycle 2
    ce_a = 1'b1; tick(); ce_a = 1'b0;          // cycle 3
    check("overrun c3", int'(overrun_a), 1);
    tick();                                    // cycle 4
    check("overrun c4", int'(overrun_a), 0);
    check("valid c4", int'(valid_a), 0);
    tick();                                    // cycle 5
    check("valid c5", int'(valid_a), 1);
    ce_a = 1'b1; tick(); ce_a = 1'b0;          // cycle 6
    check("busy c6", int'(busy_a), 1);
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin tick(); nvalid += int'(valid_a); end  // cycles 7..9
    check("no valid c7..c9", nvalid, 0);
    tick();                                    // cycle 10
    check("valid c10", int'(valid_a), 1);
    tick(); tick();

    // Reset mid-mix.
    ce_a = 1'b1; tick(); ce_a = 1'b0;          // cycle 1
    tick();                                    // cycle 2
    RESET = 1'b1; tick(); RESET = 1'b0;        // cycle 3
    check("rst busy", int'(busy_a), 0);
    check("rst audio_l", int'(audio_l_a), 0);
    check("rst audio_r", int'(audio_r_a), 0);
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin nvalid += int'(valid_a); tick(); end
    check("rst no valid", nvalid, 0);
    mix_a(1'b0, lat, nbusy, l, r);
    check("post-rst latency", lat, 5);
    check("post-rst L", l, 1600);
    check("post-rst R", r, 2000);
    tick();

    // Saturation on the NCH=5 instance.
    ch_b = '1; pan_b = '1; att_b = '0;
    mono = 1'b0; tape_bit = 1'b0; tape_vol = 2'd0;
    ce_b = 1'b1; tick(); ce_b = 1'b0;
    lat = 1; nbusy = 0;
    while (valid_b !== 1'b1 && lat < 30) begin nbusy += int'(busy_b); tick(); lat++; end
    check("sat latency", lat, 7);
    check("sat busy cycles", nbusy, 6);
    check("sat L", int'(audio_l_b), sat_exp);
    check("sat R", int'(audio_r_b), sat_exp);
    check("sat overrun", int'(overrun_b), 0);
    tick(); tick();

    // Randomized traffic: every cycle new inputs, frequent strobes, rare resets.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NCH_A; k++) ch_a[k*IN_W +: IN_W] = IN_W'($urandom);
      pan_a    = (2*NCH_A)'($urandom);
      att_a    = (2*NCH_A)'($urandom);
      mono     = ($urandom_range(0, 3) == 0);
      tape_bit = 1'($urandom);
      tape_vol = 2'($urandom);
      ce_a     = ($urandom_range(0, 2) == 0);
      RESET    = ($urandom_range(0, 99) == 0);
      tick();
    end
    ce_a = 1'b0;
    RESET = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/audio_mixer_mc.md
# audio_mixer_mc

Time-multiplexed, parametrised audio mixer that sums NCH unsigned sound channels into a stereo output pair. It applies per-channel panning and attenuation, a tape-monitor term and saturation. It sits between the PSG/sound sources and the AUDIO_L/AUDIO_R outputs of the core, with a selectable mono mode. One shared adder is stepped over the channels after each sample strobe.

## Interface
Parameters:
- NCH, 3, number of input channels (1..16)
- IN_W, 12, channel sample width (unsigned)
- OUT_W, 16, output width (unsigned); must satisfy OUT_W >= IN_W+2 and OUT_W >= 10

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- ce_sample  in  1  one-cycle mix request
- ch_in  in  NCH*IN_W  channel samples; channel k at [k*IN_W +: IN_W]
- pan  in  2*NCH  per channel: 00 off, 01 left, 10 right, 11 both
- att  in  2*NCH  per channel: 0 full, 1 >>1, 2 >>2, 3 mute
- mono  in  1  1 = both outputs carry the sum of all non-off channels
- tape_bit  in  1  tape signal
- tape_vol  in  2  0 mute, 1 low, 2 high, 3 = high
- audio_l  out  OUT_W  left sample
- audio_r  out  OUT_W  right sample
- valid  out  1  one-cycle pulse when audio_l/audio_r update
- busy  out  1  mix in progress
- overrun  out  1  one-cycle pulse when a ce_sample is dropped

## Operation
- States: IDLE, ACCUM, FINAL.
- IDLE with ce_sample=1:
  - Snapshot ch_in, pan, att, mono, tape_bit and tape_vol.
  - Clear acc_l and acc_r, set idx=0, go to ACCUM.
- ACCUM, one channel per cycle:
  - v = ch[idx] >> att[idx]; v = 0 if att=3.
  - Add v to acc_l if pan[0] (or mono with pan≠00).
  - Add v to acc_r if pan[1] (or mono with pan≠00).
  - idx increments; after channel NCH-1, go to FINAL.
- FINAL:
  - s = acc << (OUT_W-IN_W-2).
  - Add tape term T = tape_bit ? (vol1: 2^(OUT_W-10), vol2/3: 2^(OUT_W-9)) : 0 to both sides.
  - Limit the result to OUT_W bits (see Configuration), register it to audio_l/audio_r, assert valid, go to IDLE.
- Accumulator width: IN_W+clog2(NCH)+1. The shifted sum is computed at OUT_W+clog2(NCH)+1 bits, so no intermediate loss occurs.
- A ce_sample while busy=1 is ignored; overrun pulses the next cycle. The snapshot and in-progress mix are unaffected.
- Inputs that change after the strobe do not affect the current mix.
- RESET in any state:
  - State goes to IDLE; acc, idx, audio_l, audio_r go to 0.
  - valid, busy, overrun go to 0; no valid is emitted for the aborted mix.

## Timing
- ce_sample is sampled at cycle N. busy is high in cycles N+1..N+NCH+1. valid is high in cycle N+NCH+2, with new audio_l/audio_r from that cycle.
- Latency from strobe to data is NCH+2 cycles. The minimum strobe spacing is NCH+2 cycles; a strobe in cycle N+NCH+2 is accepted.
- audio_l/audio_r hold their value between valid pulses.
- Reset values: audio_l=0, audio_r=0, valid=0, busy=0, overrun=0.
- A strobe during FINAL (busy=1) is dropped and overrun pulses in the following cycle, the same cycle as valid.

## Configuration
- MIXER_SAT_EN:
  - Defined: any final sum > 2^OUT_W-1 is clamped to 2^OUT_W-1.
  - Undefined: the final sum is truncated to its low OUT_W bits (modulo 2^OUT_W) and the saturation compare logic is absent.

## Test plan
- Basic pan, NCH=3, IN_W=12, OUT_W=16:
  - Stimulus: ch=(100,200,300), pan=(01,10,11), att=0, tape muted, strobe at cycle 0.
  - Response: valid at cycle 5, audio_l=1600, audio_r=2000, busy high cycles 1..4.
- Attenuation, mono and tape:
  - Stimulus: ch=(400,400,400), att=(0,1,3), pan=(01,00,10), mono=1, tape_bit=1, tape_vol=2.
  - Response: audio_l=audio_r=(400+0+0)*4+128=1728.
- Saturation, NCH=5:
  - Stimulus: all ch=4095, pan=11, att=0.
  - Response with MIXER_SAT_EN: audio_l=audio_r=65535. Response without: 16364.
- Overrun:
  - Stimulus: strobe at cycles 0 and 2.
  - Response: overrun pulses at cycle 3; exactly one valid, at cycle 5. A strobe at cycle 5 is accepted and gives valid at cycle 10.
- Snapshot:
  - Stimulus: change ch_in to 0 at cycle 1 after a strobe with ch=(100,200,300).
  - Response: output still 1600/2000.
- Reset mid-mix:
  - Stimulus: RESET at cycle 2 of a mix.
  - Response: busy=0 and outputs 0 from cycle 3; no valid pulse. The next strobe mixes normally.
